windowed_reduction_pipe: RTL and testbench



---
 rtl/windowed_reduction_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_windowed_reduction_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/windowed_reduction_pipe.sv
// windowed_reduction_pipe: streaming out = in mod q[mod_sel] via windowed folding
// followed by a registered 3-way conditional subtraction; global-stall valid/ready.
// Optional feature macro: WRED_RANGE_CHECK_EN (flag out-of-range mod_sel on out_err).
module windowed_reduction_pipe #(
   parameter int unsigned IN_W      = 60,
   parameter int unsigned Q_W       = 30,
   parameter int unsigned WIN       = 6,
   parameter int unsigned NUM_MOD   = 13,
   parameter logic [NUM_MOD*Q_W-1:0] MODULI = {
      30'd1073479681, 30'd1072496641, 30'd1071513601, 30'd1070727169,
      30'd1069219841, 30'd1068564481, 30'd1068433409, 30'd1068236801,
      30'd1065811969, 30'd1065484289, 30'd1064697857, 30'd1063452673,
      30'd1063321601},
   parameter int unsigned REG_EVERY = 2,
   parameter int unsigned TAG_W     = 8,
   localparam int unsigned SEL_W    = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [SEL_W-1:0] in_mod_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Q_W-1:0]   out_data,
   output logic [SEL_W-1:0] out_mod_sel,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   // Width of the value entering fold i (i = fold count gives the correction input width)
   function automatic int unsigned stage_w(input int unsigned i);
      int unsigned w;
      w = IN_W;
      for (int unsigned j = 0; j < i; j++)
         w = ((w - WIN > Q_W) ? w - WIN : Q_W) + 1;
      return w;
   endfunction

   // Number of folds needed to bring IN_W bits down to Q_W+1 bits
   function automatic int unsigned fold_cnt(input int unsigned in_w);
      int unsigned w;
      int unsigned n;
      w = in_w;
      n = 0;
      for (int unsigned j = 0; j < in_w; j++) begin
         if (w > Q_W + 1) begin
            w = ((w - WIN > Q_W) ? w - WIN : Q_W) + 1;
            n++;
         end
      end
      return n;
   endfunction

   // Table entry (k * 2^sh) mod q, evaluated at elaboration
   function automatic logic [Q_W-1:0] fold_tbl(input logic [Q_W-1:0] q,
                                               input int unsigned sh,
                                               input int unsigned k);
      logic [Q_W:0]       p;
      logic [Q_W+WIN-1:0] prod;
      p = (Q_W+1)'(1);
      for (int unsigned j = 0; j < sh; j++) begin
         p = p << 1;
         if (p >= {1'b0, q}) p = p - {1'b0, q};
      end
      prod = (Q_W+WIN)'(k) * (Q_W+WIN)'(p);
      prod = prod % (Q_W+WIN)'(q);
      return prod[Q_W-1:0];
   endfunction

   // Out-of-range indices use the last modulus
   function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
      return (32'(s) >= NUM_MOD) ? SEL_W'(NUM_MOD - 1) : s;
   endfunction

   localparam int unsigned F     = fold_cnt(IN_W);
   localparam int unsigned X_W   = stage_w(F);
   localparam int unsigned TBL_N = 2 ** WIN;

   logic advance_c;
   logic in_take_c;
   logic in_err_c;

   // Global stall: everything moves only when the output slot is free or draining
   assign advance_c = out_ready | ~out_valid;
   assign in_ready  = advance_c;
   assign in_take_c = in_valid & advance_c;

`ifdef WRED_RANGE_CHECK_EN
   assign in_err_c = (32'(in_mod_sel) >= NUM_MOD);
`else
   assign in_err_c = 1'b0;
`endif

   for (genvar i = 0; i < F; i++) begin : g_fold
      localparam int unsigned W   = stage_w(i);
      localparam int unsigned WO  = stage_w(i + 1);
      localparam int unsigned LOW = W - WIN;
      localparam bit          REG = (((i + 1) % REG_EVERY) == 0) && (i != F - 1);

      logic [W-1:0]     x_in;
      logic [SEL_W-1:0] sel_in;
      logic [TAG_W-1:0] tag_in;
      logic             err_in;
      logic             vld_in;
      logic [WO-1:0]    sum_c;
      logic [WO-1:0]    x_out;
      logic [SEL_W-1:0] sel_out;
      logic [TAG_W-1:0] tag_out;
      logic             err_out;
      logic             vld_out;
      logic [Q_W-1:0]   tbl [NUM_MOD][TBL_N];

      if (i == 0) begin : g_src
         assign x_in   = in_data;
         assign sel_in = in_mod_sel;
         assign tag_in = in_tag;
         assign err_in = in_err_c;
         assign vld_in = in_take_c;
      end else begin : g_src
         assign x_in   = g_fold[i-1].x_out;
         assign sel_in = g_fold[i-1].sel_out;
         assign tag_in = g_fold[i-1].tag_out;
         assign err_in = g_fold[i-1].err_out;
         assign vld_in = g_fold[i-1].vld_out;
      end

      for (genvar m = 0; m < NUM_MOD; m++) begin : g_mod
         for (genvar k = 0; k < TBL_N; k++) begin : g_ent
            localparam logic [Q_W-1:0] T = fold_tbl(MODULI[m*Q_W +: Q_W], LOW, k);
            assign tbl[m][k] = T;
         end
      end

      // Replace the top WIN bits by their precomputed residue
      assign sum_c = WO'(x_in[LOW-1:0]) + WO'(tbl[clamp_sel(sel_in)][x_in[W-1 -: WIN]]);

      if (REG) begin : g_reg
         // Pipeline register after every REG_EVERY-th fold, frozen while stalled
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               x_out   <= '0;
               sel_out <= '0;
               tag_out <= '0;
               err_out <= 1'b0;
               vld_out <= 1'b0;
            end else if (advance_c) begin
               x_out   <= sum_c;
               sel_out <= sel_in;
               tag_out <= tag_in;
               err_out <= err_in;
               vld_out <= vld_in;
            end
         end
      end else begin : g_comb
         assign x_out   = sum_c;
         assign sel_out = sel_in;
         assign tag_out = tag_in;
         assign err_out = err_in;
         assign vld_out = vld_in;
      end
   end

   logic [X_W-1:0]   x_fin;
   logic [SEL_W-1:0] sel_fin;
   logic [TAG_W-1:0] tag_fin;
   logic             err_fin;
   logic             vld_fin;
   logic [Q_W+1:0]   xe_c;
   logic [Q_W+1:0]   q1_c;
   logic [Q_W+1:0]   q2_c;
   logic [Q_W+1:0]   q3_c;
   logic [Q_W-1:0]   corr_c;

   assign x_fin   = g_fold[F-1].x_out;
   assign sel_fin = g_fold[F-1].sel_out;
   assign tag_fin = g_fold[F-1].tag_out;
   assign err_fin = g_fold[F-1].err_out;
   assign vld_fin = g_fold[F-1].vld_out;

   // Final correction: x < 4q, pick the smallest non-negative of x - {0,1,2,3}q
   always_comb begin
      q1_c   = (Q_W+2)'(MODULI[clamp_sel(sel_fin)*Q_W +: Q_W]);
      q2_c   = q1_c << 1;
      q3_c   = q1_c + q2_c;
      xe_c   = (Q_W+2)'(x_fin);
      corr_c = Q_W'(xe_c);
      if (xe_c >= q3_c)      corr_c = Q_W'(xe_c - q3_c);
      else if (xe_c >= q2_c) corr_c = Q_W'(xe_c - q2_c);
      else if (xe_c >= q1_c) corr_c = Q_W'(xe_c - q1_c);
   end

   // Output register; holds while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_mod_sel <= '0;
         out_tag     <= '0;
         out_err     <= 1'b0;
      end else if (advance_c) begin
         out_valid   <= vld_fin;
         out_data    <= err_fin ? '0 : corr_c;
         out_mod_sel <= sel_fin;
         out_tag     <= tag_fin;
         out_err     <= err_fin & vld_fin;
      end
   end

endmodule

// File: tb/tb_windowed_reduction_pipe.sv
// Bench for windowed_reduction_pipe: default instance plus an IN_W=62/WIN=4/REG_EVERY=1
// instance driven in lockstep, both checked against a % based reference model.
module tb_windowed_reduction_pipe;
   localparam int unsigned NUM_MOD = 13;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [59:0] in_data;
   logic [61:0] in_data2;
   logic [3:0]  in_mod_sel;
   logic [7:0]  in_tag;
   logic        out_ready;

   logic        in_ready,    in_ready2;
   logic        out_valid,   out_valid2;
   logic [29:0] out_data,    out_data2;
   logic [3:0]  out_mod_sel, out_mod_sel2;
   logic [7:0]  out_tag,     out_tag2;
   logic        out_err,     out_err2;

   always #5 clk = ~clk;

   windowed_reduction_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mod_sel(in_mod_sel), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mod_sel(out_mod_sel), .out_tag(out_tag), .out_err(out_err));

   windowed_reduction_pipe #(.IN_W(62), .WIN(4), .REG_EVERY(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data2), .in_mod_sel(in_mod_sel), .in_tag(in_tag),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_mod_sel(out_mod_sel2), .out_tag(out_tag2), .out_err(out_err2));

   typedef struct {
      longint unsigned data;
      logic [7:0]      tag;
      logic [3:0]      sel;
      logic            err;
   } exp_t;

   longint unsigned qtab [NUM_MOD] = '{
      64'd1063321601, 64'd1063452673, 64'd1064697857, 64'd1065484289,
      64'd1065811969, 64'd1068236801, 64'd1068433409, 64'd1068564481,
      64'd1069219841, 64'd1070727169, 64'd1071513601, 64'd1072496641,
      64'd1073479681};

   exp_t            q1[$];
   exp_t            q2[$];
   longint unsigned log1[$];
   logic            logerr1[$];

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   first_acc, first_v1, first_v2, last_v1, nv1, nv2;
   int   n_emit1 = 0;
   bit   acc1;
   bit   stall_prev1 = 1'b0;
   bit   stall_prev2 = 1'b0;
   logic [29:0] held1, held2;
   logic [7:0]  heldt1, heldt2;

   // Golden: plain modular arithmetic on the whole input value
   function automatic exp_t model(input longint unsigned x, input logic [3:0] sel,
                                  input logic [7:0] tag);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.err = 1'b0;
      if (int'(sel) >= NUM_MOD) begin
`ifdef WRED_RANGE_CHECK_EN
         e.err  = 1'b1;
         e.data = 64'd0;
`else
         e.data = x % qtab[NUM_MOD-1];
`endif
      end else begin
         e.data = x % qtab[sel];
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
         else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, got, exp);
         end
   endtask

   task automatic clear_stats();
      first_acc = -1; first_v1 = -1; first_v2 = -1; last_v1 = -1; nv1 = 0; nv2 = 0;
   endtask

   // One cycle: drive at negedge, then account handshakes for the coming posedge
   task automatic step(input logic v, input logic [61:0] d, input logic [3:0] s,
                       input logic [7:0] t, input logic ordy);
      exp_t e;
      @(negedge clk);
      in_valid = v; in_data = d[59:0]; in_data2 = d; in_mod_sel = s; in_tag = t;
      out_ready = ordy;
      #1;
      cyc++;
      acc1 = 1'b0;
      if (out_valid) begin
         if (first_v1 < 0) first_v1 = cyc;
         last_v1 = cyc;
         nv1++;
      end
      if (out_valid2) begin
         if (first_v2 < 0) first_v2 = cyc;
         nv2++;
      end
      if (stall_prev1) begin
         chk("hold_valid1", 64'(out_valid), 64'd1);
         chk("hold_data1", 64'(out_data), 64'(held1));
         chk("hold_tag1", 64'(out_tag), 64'(heldt1));
      end
      if (stall_prev2) begin
         chk("hold_data2", 64'(out_data2), 64'(held2));
         chk("hold_tag2", 64'(out_tag2), 64'(heldt2));
      end
      stall_prev1 = out_valid & ~out_ready;
      stall_prev2 = out_valid2 & ~out_ready;
      held1 = out_data; heldt1 = out_tag; held2 = out_data2; heldt2 = out_tag2;
      if (out_valid && out_ready) begin
         n_emit1++;
         log1.push_back(64'(out_data));
         logerr1.push_back(out_err);
         chk("emit_expected1", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("data1", 64'(out_data), e.data);
            chk("side1", {51'd0, out_err, out_mod_sel, out_tag}, {51'd0, e.err, e.sel, e.tag});
         end
      end
      if (out_valid2 && out_ready) begin
         chk("emit_expected2", 64'(q2.size() != 0), 64'd1);
         if (q2.size() != 0) begin
            e = q2.pop_front();
            chk("data2", 64'(out_data2), e.data);
            chk("side2", {51'd0, out_err2, out_mod_sel2, out_tag2}, {51'd0, e.err, e.sel, e.tag});
         end
      end
      if (in_valid && in_ready) begin
         acc1 = 1'b1;
         if (first_acc < 0) first_acc = cyc;
         q1.push_back(model(64'(d[59:0]), s, t));
      end
      if (in_valid && in_ready2) q2.push_back(model(64'(d), s, t));
   endtask

   task automatic drain(input int max_cyc);
      for (int i = 0; i < max_cyc && (q1.size() != 0 || q2.size() != 0); i++)
         step(1'b0, 62'd0, 4'd0, 8'd0, 1'b1);
      chk("drain_q1", 64'(q1.size()), 64'd0);
      chk("drain_q2", 64'(q2.size()), 64'd0);
   endtask

   function automatic logic [61:0] rand_data();
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r == 0) return {62{1'b1}};
      if (r == 1) return 62'(longint'($urandom_range(0, 5)) * 64'(qtab[$urandom_range(0, 12)])
                             + 64'($urandom_range(0, 3)));
      return 62'({$urandom(), $urandom()});
   endfunction

   longint unsigned big;
   logic [61:0]     cur_d;
   int              idx;
   int              base_emit;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_data2 = '0;
      in_mod_sel = '0; in_tag = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_side", {51'd0, out_err, out_mod_sel, out_tag}, 64'd0);
      chk("rst_out_valid2", 64'(out_valid2), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;

      // Back-to-back directed samples, latency and contiguous output window
      clear_stats();
      log1.delete();
      step(1'b1, 62'd0,                       4'd0, 8'h11, 1'b1);
      step(1'b1, 62'd1063321601,              4'd0, 8'h22, 1'b1);
      step(1'b1, 62'd5316608012,              4'd0, 8'h33, 1'b1);
      step(1'b1, 62'd1073741824,              4'd0, 8'h44, 1'b1);
      drain(30);
      chk("lat_default", 64'(first_v1 - first_acc), 64'd3);
      chk("valid_cycles", 64'(nv1), 64'd4);
      chk("valid_contig", 64'(last_v1 - first_v1), 64'd3);
      chk("lat_alt", 64'(first_v2 - first_acc), 64'd11);
      chk("valid_cycles2", 64'(nv2), 64'd4);
      chk("dir_count", 64'(log1.size()), 64'd4);
      if (log1.size() == 4) begin
         chk("dir0", log1[0], 64'd0);
         chk("dir1", log1[1], 64'd0);
         chk("dir2", log1[2], 64'd7);
         chk("dir3", log1[3], 64'd10420223);
      end

      // Largest products
      log1.delete();
      big = 64'd1063321601 * 64'd1063321601 - 64'd1;
      step(1'b1, 62'(big), 4'd0, 8'h55, 1'b1);
      step(1'b1, 62'h0FFF_FFFF_FFFF_FFFF, 4'd12, 8'h66, 1'b1);
      step(1'b1, {62{1'b1}}, 4'd12, 8'h67, 1'b1);
      drain(30);
      if (log1.size() != 0) chk("sq_minus_1", log1[0], 64'd1063321600);

      // Randomized traffic with random backpressure and bubbles
      for (int i = 0; i < 3000; i++)
         step(1'b1 & ($urandom_range(0, 4) != 0), rand_data(),
              ($urandom_range(0, 15) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12)),
              8'($urandom), $urandom_range(0, 3) != 0);
      drain(60);

      // Stream of 20 with out_ready low for stream cycles 5..8
      base_emit = n_emit1;
      idx = 0;
      cur_d = rand_data();
      for (int k = 0; k < 80 && idx < 20; k++) begin
         step(1'b1, cur_d, 4'(idx % 13), 8'(100 + idx), !(k >= 5 && k <= 8));
         if (k >= 5 && k <= 8) chk("stall_in_ready", 64'(in_ready), 64'd0);
         if (acc1) begin
            idx++;
            cur_d = rand_data();
         end
      end
      drain(60);
      chk("stall_delivered", 64'(n_emit1 - base_emit), 64'd20);

      // Reset with samples in flight
      for (int k = 0; k < 6; k++) step(1'b1, rand_data(), 4'(k), 8'(200 + k), 1'b1);
      #2;
      chk("pre_reset_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_data", 64'(out_data), 64'd0);
      q1.delete(); q2.delete();
      stall_prev1 = 1'b0; stall_prev2 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 62'd0, 4'd0, 8'd0, 1'b1);
         chk("post_rst_idle", {62'd0, out_valid, out_valid2}, 64'd0);
      end
      log1.delete();
      step(1'b1, 62'd5316608012, 4'd0, 8'h77, 1'b1);
      drain(30);
      if (log1.size() != 0) chk("post_rst_sample", log1[0], 64'd7);

      // Out-of-range modulus index
      log1.delete(); logerr1.delete();
      step(1'b1, 62'd1073741824, 4'd13, 8'h5A, 1'b1);
      drain(30);
      chk("range_count", 64'(log1.size()), 64'd1);
      if (log1.size() != 0) begin
`ifdef WRED_RANGE_CHECK_EN
         chk("range_data", log1[0], 64'd0);
         chk("range_err", 64'(logerr1[0]), 64'd1);
`else
         chk("range_data", log1[0], 64'd262143);
         chk("range_err", 64'(logerr1[0]), 64'd0);
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
